// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode types for the decode stage.
// Holds the ALU operation encoding, base opcode constants, the immediate
// format enum and two small helpers for the immediate and ALU-op mapping.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10   // pass the immediate straight through
   } alu_op_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_fmt_t;

   // Sign-extended immediate for the given format; R-type has none.
   function automatic logic [31:0] build_imm(input imm_fmt_t fmt, input logic [31:0] i);
      logic [31:0] r;
      case (fmt)
         IMM_I:   r = {{20{i[31]}}, i[31:20]};
         IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_U:   r = {i[31:12], 12'b0};
         IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // funct3/funct7[5] to ALU op. Bit 30 selects SUB only for register ops
   // (for OP-IMM it is an immediate bit); it selects SRA/SRAI for both.
   function automatic alu_op_t arith_op(input logic [2:0] f3, input logic f7b5,
                                        input logic is_imm);
      alu_op_t r;
      case (f3)
         3'b000:  r = (f7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/RegisterFile.sv
// RegisterFile: 31 writable 32-bit registers, x0 hard-wired to zero.
// Writes land on the falling edge; reads are combinational with
// same-cycle write-through so decode sees a value being written back now.
module RegisterFile (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);

   logic [31:0] regs [1:31];

   // Storage update: reset clears everything and drops any concurrent write.
   always_ff @(negedge clk) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) regs[i] <= 32'h0;
      end else if (we && waddr != 5'd0) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports with x0 rule and write-through from the writeback port.
   always_comb begin
      rdata1 = 32'h0;
      rdata2 = 32'h0;
      if (raddr1 != 5'd0)
         rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
      if (raddr2 != 5'd0)
         rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
   end

endmodule

// File: rtl/stage_2_decode.sv
// stage_2_decode: RV32I decode stage with register read, immediate build,
// load-use hazard detection and a falling-edge output register.
// Optional macro DECODE_ILLEGAL_EN: when defined, unsupported nonzero
// opcodes issue as valid=1/illegal=1; otherwise they become bubbles.
module stage_2_decode
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [31:0] next_address,
   input  logic        flush,
   input  logic        wb_enable,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic [31:0] rs1_value,
   output logic [31:0] rs2_value,
   output logic [31:0] imm,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [31:0] pc_next_out,
   output logic [3:0]  alu_op,
   output logic        alu_src_imm,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        branch,
   output logic        jump,
   output logic        valid,
   output logic        illegal
);

   logic [6:0]  opcode;
   logic [4:0]  rs1_a, rs2_a;
   logic [31:0] rf_rs1, rf_rs2;
   logic        supported, use_rs1, use_rs2;
   imm_fmt_t    fmt;
   alu_op_t     d_alu;
   logic        d_src, d_mr, d_mw, d_rw, d_br, d_j;
   logic        hazard, issue, take_illegal;

   assign opcode = instruction[6:0];
   assign rs1_a  = instruction[19:15];
   assign rs2_a  = instruction[24:20];

   RegisterFile u_rf (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_enable),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (rs1_a),
      .raddr2 (rs2_a),
      .rdata1 (rf_rs1),
      .rdata2 (rf_rs2)
   );

   // Opcode decode: controls, immediate format and which sources are read.
   always_comb begin
      supported = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      fmt       = IMM_R;
      d_alu     = ALU_ADD;
      d_src     = 1'b0;
      d_mr      = 1'b0;
      d_mw      = 1'b0;
      d_rw      = 1'b0;
      d_br      = 1'b0;
      d_j       = 1'b0;
      case (opcode)
         OPC_LUI:    begin supported = 1'b1; fmt = IMM_U; d_alu = ALU_LUI; d_src = 1'b1; d_rw = 1'b1; end
         OPC_AUIPC:  begin supported = 1'b1; fmt = IMM_U; d_src = 1'b1; d_rw = 1'b1; end
         OPC_JAL:    begin supported = 1'b1; fmt = IMM_J; d_src = 1'b1; d_rw = 1'b1; d_j = 1'b1; end
         OPC_JALR:   begin supported = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; d_src = 1'b1; d_rw = 1'b1; d_j = 1'b1; end
         OPC_BRANCH: begin supported = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B; d_alu = ALU_SUB; d_br = 1'b1; end
         OPC_LOAD:   begin supported = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; d_src = 1'b1; d_mr = 1'b1; d_rw = 1'b1; end
         OPC_STORE:  begin supported = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S; d_src = 1'b1; d_mw = 1'b1; end
         OPC_OPIMM:  begin
            supported = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; d_src = 1'b1; d_rw = 1'b1;
            d_alu = arith_op(instruction[14:12], instruction[30], 1'b1);
         end
         OPC_OP:     begin
            supported = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d_rw = 1'b1;
            d_alu = arith_op(instruction[14:12], instruction[30], 1'b0);
         end
         default: ;
      endcase
   end

   // A load in the output register whose destination this instruction reads.
   assign hazard = valid && mem_read && (rd != 5'd0) &&
                   ((use_rs1 && rs1_a == rd) || (use_rs2 && rs2_a == rd));
   // Flush squashes this decode, so holding fetch would be pointless.
   assign stall  = hazard && !flush && !reset;
   assign issue  = supported && (instruction != 32'h0) && !flush && !stall;

`ifdef DECODE_ILLEGAL_EN
   assign take_illegal = !supported && (instruction != 32'h0) && !flush;

   // Illegal flag register; only exists when illegal reporting is enabled.
   always_ff @(negedge clk) begin
      if (reset) illegal <= 1'b0;
      else       illegal <= take_illegal;
   end
`else
   assign take_illegal = 1'b0;
   assign illegal      = 1'b0;
`endif

   // Output register: decoded result, or all-zero controls for a bubble.
   always_ff @(negedge clk) begin
      if (reset) begin
         valid       <= 1'b0;
         pc_next_out <= RESET_PC;
         rs1_value   <= 32'h0;
         rs2_value   <= 32'h0;
         imm         <= 32'h0;
         rd          <= 5'd0;
         funct3      <= 3'd0;
         alu_op      <= 4'd0;
         alu_src_imm <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         reg_write   <= 1'b0;
         branch      <= 1'b0;
         jump        <= 1'b0;
      end else begin
         valid       <= issue || take_illegal;
         pc_next_out <= next_address;
         if (issue) begin
            rs1_value   <= rf_rs1;
            rs2_value   <= rf_rs2;
            imm         <= build_imm(fmt, instruction);
            rd          <= d_rw ? instruction[11:7] : 5'd0;
            funct3      <= instruction[14:12];
            alu_op      <= d_alu;
            alu_src_imm <= d_src;
            mem_read    <= d_mr;
            mem_write   <= d_mw;
            reg_write   <= d_rw;
            branch      <= d_br;
            jump        <= d_j;
         end else begin
            rs1_value   <= 32'h0;
            rs2_value   <= 32'h0;
            imm         <= 32'h0;
            rd          <= 5'd0;
            funct3      <= 3'd0;
            alu_op      <= 4'd0;
            alu_src_imm <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            reg_write   <= 1'b0;
            branch      <= 1'b0;
            jump        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stage_2_decode.sv
// tb_stage_2_decode: directed scenarios plus randomized traffic checked
// against an instruction-level reference model of the decode stage.
module tb_stage_2_decode;
   import riscv_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset = 1'b0, flush = 1'b0, wb_enable = 1'b0;
   logic [31:0] instruction = 32'h0, next_address = 32'h0, wb_data = 32'h0;
   logic [4:0]  wb_rd = 5'd0;
   logic        stall;
   logic [31:0] rs1_value, rs2_value, imm, pc_next_out;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [3:0]  alu_op;
   logic        alu_src_imm, mem_read, mem_write, reg_write, branch, jump, valid, illegal;

   stage_2_decode #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .instruction(instruction), .next_address(next_address),
      .flush(flush), .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall), .rs1_value(rs1_value), .rs2_value(rs2_value), .imm(imm), .rd(rd),
      .funct3(funct3), .pc_next_out(pc_next_out), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
      .jump(jump), .valid(valid), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid, illegal;
      logic [3:0]  alu;
      logic        src, mr, mw, rw, br, j;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] imm, v1, v2, pc;
   } out_t;

   out_t got, exp;
   logic exp_stall = 1'b0, stall_seen;
   logic [31:0] mregs [32];
   logic [31:0] pc_cnt = 32'h0000_2000;
   int checks = 0, passes = 0;

   assign got = {valid, illegal, alu_op, alu_src_imm, mem_read, mem_write, reg_write,
                 branch, jump, rd, funct3, imm, rs1_value, rs2_value, pc_next_out};

   // ---------------- reference model ----------------
   function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
      logic signed [31:0] t;
      t = v << (32 - bits);
      return t >>> (32 - bits);
   endfunction

   // Register value as seen by decode this cycle (writeback visible at once).
   function automatic logic [31:0] rv(input logic [4:0] r);
      if (r == 0) return 32'h0;
      if (wb_enable && wb_rd == r) return wb_data;
      return mregs[r];
   endfunction

   function automatic logic uses1(input logic [6:0] op);
      return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
   endfunction

   function automatic logic uses2(input logic [6:0] op);
      return op inside {7'h63, 7'h23, 7'h33};
   endfunction

   function automatic logic [3:0] mop(input logic [2:0] f3, input logic b30, input logic is_op);
      case (f3)
         0: return (is_op && b30) ? ALU_SUB : ALU_ADD;
         1: return ALU_SLL;
         2: return ALU_SLT;
         3: return ALU_SLTU;
         4: return ALU_XOR;
         5: return b30 ? ALU_SRA : ALU_SRL;
         6: return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic out_t mdecode(input logic [31:0] ins, input logic [31:0] na);
      out_t o;
      logic [31:0] ii, si, bi, ui, ji;
      o = '0;
      o.pc = na;
      if (ins == 32'h0) return o;
      ii = sx(ins >> 20, 12);
      si = sx(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F), 12);
      bi = sx((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
              (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
      ui = ins & 32'hFFFF_F000;
      ji = sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
              (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
      o.valid = 1'b1;
      case (ins[6:0])
         7'h37: begin o.alu = ALU_LUI; o.src = 1; o.rw = 1; o.imm = ui; end
         7'h17: begin o.alu = ALU_ADD; o.src = 1; o.rw = 1; o.imm = ui; end
         7'h6F: begin o.alu = ALU_ADD; o.src = 1; o.rw = 1; o.j = 1; o.imm = ji; end
         7'h67: begin o.alu = ALU_ADD; o.src = 1; o.rw = 1; o.j = 1; o.imm = ii; end
         7'h63: begin o.alu = ALU_SUB; o.br = 1; o.imm = bi; end
         7'h03: begin o.alu = ALU_ADD; o.src = 1; o.mr = 1; o.rw = 1; o.imm = ii; end
         7'h23: begin o.alu = ALU_ADD; o.src = 1; o.mw = 1; o.imm = si; end
         7'h13: begin o.alu = mop(ins[14:12], ins[30], 0); o.src = 1; o.rw = 1; o.imm = ii; end
         7'h33: begin o.alu = mop(ins[14:12], ins[30], 1); o.rw = 1; o.imm = 0; end
         default: begin
            o.valid = 1'b0;
`ifdef DECODE_ILLEGAL_EN
            o.valid = 1'b1;
            o.illegal = 1'b1;
`endif
            return o;
         end
      endcase
      o.f3 = ins[14:12];
      o.rd = o.rw ? ins[11:7] : 5'd0;
      o.v1 = rv(ins[19:15]);
      o.v2 = rv(ins[24:20]);
      return o;
   endfunction

   task automatic model_step();
      out_t n;
      logic st;
      st = !reset && !flush && exp.valid && exp.mr && exp.rd != 0 &&
           ((uses1(instruction[6:0]) && instruction[19:15] == exp.rd) ||
            (uses2(instruction[6:0]) && instruction[24:20] == exp.rd));
      exp_stall = st;
      if (reset) begin
         n = '0;
         n.pc = RPC;
         for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      end else begin
         n = mdecode(instruction, next_address);
         if (flush || st) begin
            n = '0;
            n.pc = next_address;
         end
         if (wb_enable && wb_rd != 0) mregs[wb_rd] = wb_data;
      end
      exp = n;
   endtask

   // Drive one cycle of inputs after the rising edge, capture stall, then
   // let the falling edge update the DUT; outputs are stable on return.
   task automatic step(input logic r, input logic f, input logic [31:0] ins,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
      @(posedge clk);
      #1;
      reset = r; flush = f; instruction = ins; next_address = pc_cnt;
      wb_enable = we; wb_rd = wr; wb_data = wd;
      pc_cnt = pc_cnt + 4;
      #1;
      stall_seen = stall;
      model_step();
      @(negedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      out_t z;
      z = '0;
      z.pc = RPC;
      step(1, 0, 32'h00500093, 1, 5'd3, 32'h55);
      step(1, 1, 32'h00500093, 0, 5'd0, 32'h0);
      checks++; if (got !== z) $display("FAIL reset_outputs got=%h exp=%h", got, z); else passes++;
      checks++; if (stall_seen !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_seen); else passes++;
   endtask

   task automatic test_addi();
      step(0, 0, 32'h00500093, 0, 5'd0, 32'h0);
      checks++;
      if (valid !== 1 || rd !== 5'd1 || imm !== 32'd5 || alu_src_imm !== 1 || reg_write !== 1 || rs1_value !== 0)
         $display("FAIL addi got v=%b rd=%0d imm=%h src=%b rw=%b rs1=%h", valid, rd, imm, alu_src_imm, reg_write, rs1_value);
      else passes++;
      checks++; if (got !== exp) $display("FAIL addi_model got=%h exp=%h", got, exp); else passes++;
   endtask

   task automatic test_writethrough();
      step(0, 0, 32'h002101B3, 1, 5'd2, 32'hDEAD);   // add x3,x2,x2 with wb x2
      checks++;
      if (rs1_value !== 32'hDEAD || rs2_value !== 32'hDEAD)
         $display("FAIL writethrough got rs1=%h rs2=%h exp=0000dead", rs1_value, rs2_value);
      else passes++;
      step(0, 0, 32'h00010233, 0, 5'd0, 32'h0);      // add x4,x2,x0 reads stored x2
      checks++; if (rs1_value !== 32'hDEAD) $display("FAIL wb_stored got=%h exp=0000dead", rs1_value); else passes++;
      checks++; if (got !== exp) $display("FAIL wb_model got=%h exp=%h", got, exp); else passes++;
   endtask

   task automatic test_load_use();
      step(0, 0, 32'h0000A283, 0, 5'd0, 32'h0);      // lw x5,0(x1)
      checks++; if (mem_read !== 1 || rd !== 5'd5) $display("FAIL lw_issue got mr=%b rd=%0d exp mr=1 rd=5", mem_read, rd); else passes++;
      step(0, 0, 32'h00028333, 0, 5'd0, 32'h0);      // add x6,x5,x0
      checks++; if (stall_seen !== 1'b1) $display("FAIL loaduse_stall got=%b exp=1", stall_seen); else passes++;
      checks++; if (valid !== 1'b0 || got !== exp) $display("FAIL loaduse_bubble got=%h exp=%h", got, exp); else passes++;
      step(0, 0, 32'h00028333, 0, 5'd0, 32'h0);
      checks++; if (stall_seen !== 1'b0) $display("FAIL loaduse_release got=%b exp=0", stall_seen); else passes++;
      checks++; if (valid !== 1'b1 || rd !== 5'd6) $display("FAIL loaduse_issue got v=%b rd=%0d exp v=1 rd=6", valid, rd); else passes++;
   endtask

   task automatic test_flush_x0();
      step(0, 0, 32'h0000A283, 0, 5'd0, 32'h0);
      step(0, 1, 32'h00028333, 0, 5'd0, 32'h0);      // flush over a hazard
      checks++; if (stall_seen !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall_seen); else passes++;
      checks++; if (valid !== 1'b0 || got !== exp) $display("FAIL flush_bubble got=%h exp=%h", got, exp); else passes++;
      step(0, 0, 32'h000003B3, 1, 5'd0, 32'hFFFF_FFFF); // add x7,x0,x0 with wb x0
      checks++; if (rs1_value !== 0 || rs2_value !== 0) $display("FAIL x0_fwd got rs1=%h rs2=%h exp=0", rs1_value, rs2_value); else passes++;
      step(0, 0, 32'h000003B3, 0, 5'd0, 32'h0);
      checks++; if (rs1_value !== 0) $display("FAIL x0_stored got=%h exp=0", rs1_value); else passes++;
   endtask

   task automatic test_illegal();
      step(0, 0, 32'h00000073, 0, 5'd0, 32'h0);
`ifdef DECODE_ILLEGAL_EN
      checks++; if (valid !== 1 || illegal !== 1 || reg_write !== 0 || alu_src_imm !== 0)
         $display("FAIL illegal got v=%b ill=%b exp v=1 ill=1", valid, illegal); else passes++;
`else
      checks++; if (valid !== 0 || illegal !== 0)
         $display("FAIL unsupported got v=%b ill=%b exp v=0 ill=0", valid, illegal); else passes++;
`endif
      checks++; if (got !== exp) $display("FAIL illegal_model got=%h exp=%h", got, exp); else passes++;
      step(0, 0, 32'h00000000, 0, 5'd0, 32'h0);
      checks++; if (valid !== 0 || illegal !== 0) $display("FAIL zero_inst got v=%b ill=%b exp 0 0", valid, illegal); else passes++;
   endtask

   task automatic test_reset_mid();
      out_t z;
      step(0, 0, 32'h00500093, 1, 5'd2, 32'h1234);
      step(1, 0, 32'h002101B3, 1, 5'd4, 32'h9999);   // wb during reset dropped
      z = '0;
      z.pc = RPC;
      checks++; if (got !== z) $display("FAIL reset_mid got=%h exp=%h", got, z); else passes++;
      step(0, 0, 32'h002101B3, 0, 5'd0, 32'h0);
      checks++; if (rs1_value !== 0) $display("FAIL reset_clear_x2 got=%h exp=0", rs1_value); else passes++;
      step(0, 0, 32'h004202B3, 0, 5'd0, 32'h0);
      checks++; if (rs1_value !== 0) $display("FAIL reset_drop_wb got=%h exp=0", rs1_value); else passes++;
   endtask

   task automatic test_random();
      logic [6:0] ops [11];
      logic [31:0] ins;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 10)];
         ins[11:7]  = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) ins = 32'h0;
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, ins,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         checks++; if (stall_seen !== exp_stall) $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall_seen, exp_stall); else passes++;
         checks++; if (got !== exp) $display("FAIL rand_out n=%0d got=%h exp=%h", n, got, exp); else passes++;
      end
   endtask

   initial begin
      exp = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      test_reset();
      test_addi();
      test_writethrough();
      test_load_use();
      test_flush_x0();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/stage_2_decode.md
STAGE_2_DECODE -- requirements
Module: stage_2_decode

Interface
REQ-001 SHALL expose parameter RESET_PC, default 32'h0, value driven on pc_next_out during reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on negedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on negedge clk.
REQ-004 SHALL have ports instruction (input, 32: fetched instruction) and next_address (input, 32: PC+4 of that instruction).
REQ-005 SHALL have port flush  input  1  taken branch/jump from execute; squash the current decode.
REQ-006 SHALL have ports wb_enable (input, 1), wb_rd (input, 5) and wb_data (input, 32): writeback write port.
REQ-007 SHALL have port stall  output  1  combinational load-use hazard; fetch holds while it is high.
REQ-008 SHALL have registered outputs rs1_value (32), rs2_value (32), imm (32), rd (5), funct3 (3) and pc_next_out (32).
REQ-009 SHALL have registered outputs alu_op (4, alu_op_t), alu_src_imm, mem_read, mem_write, reg_write, branch, jump, valid and illegal (1 bit each).

Function
REQ-010 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP; every other opcode is unsupported.
REQ-011 SHALL build a sign-extended I/S/B/U/J immediate selected by opcode; U-type SHALL be {inst[31:12],12'b0}; R-type SHALL give imm=0.
REQ-012 SHALL map funct3/funct7[5] to alu_op; SUB/SRA only for OP, SRAI only for OP-IMM with funct7[5]=1.
REQ-013 SHALL read rs1/rs2 from the 32x32 register file; x0 SHALL read 0.
REQ-014 SHALL write wb_data to wb_rd on negedge when wb_enable=1 and wb_rd!=0; writes to x0 SHALL be ignored.
REQ-015 SHALL forward wb_data to rs1_value/rs2_value when wb_enable=1 and wb_rd equals that nonzero source (same-cycle write-through).
REQ-016 SHALL assert stall when the output register holds valid=1, mem_read=1, rd!=0, and rd equals an rs1/rs2 actually used by the current opcode.
REQ-017 SHALL load a bubble (valid=0, every control output 0) when stall=1; register file writes SHALL still occur.
REQ-018 SHALL give flush priority: on flush=1, load a bubble and force stall=0 the same cycle.
REQ-019 SHALL treat instruction==32'h0 as a bubble (valid=0, illegal=0).
REQ-020 SHALL otherwise register the decoded result with valid=1; latency from instruction to outputs is one negedge.

Reset
REQ-021 SHALL, on reset, clear all outputs to 0 (pc_next_out=RESET_PC) and clear all 31 writable registers to 0.
REQ-022 SHALL let reset override flush, stall and writeback; a wb write in a reset cycle SHALL be dropped.

Configuration
REQ-023 SHALL honour macro DECODE_ILLEGAL_EN.
REQ-024 With DECODE_ILLEGAL_EN defined, an unsupported nonzero opcode SHALL produce illegal=1 and valid=1 with all other controls 0.
REQ-025 Without DECODE_ILLEGAL_EN, illegal SHALL be tied 0 and an unsupported opcode SHALL produce a bubble (valid=0).

Structure
REQ-026 Package riscv_pkg SHALL hold alu_op_t, opcode constants, and imm-format enum.
REQ-027 Sub-module RegisterFile SHALL hold storage, x0 rule, reset clearing and write-through; decode, imm and hazard logic stay in stage_2_decode.

Verification
REQ-028 addi x1,x0,5 (32'h00500093) -> next negedge: valid=1, rd=1, imm=5, alu_src_imm=1, reg_write=1, rs1_value=0.
REQ-029 wb x2=32'hDEAD, same cycle add x3,x2,x2 -> rs1_value=rs2_value=32'hDEAD.
REQ-030 lw x5,0(x1), then add x6,x5,x0 -> stall=1 one cycle, bubble emitted, then add issues with valid=1.
REQ-031 flush=1 concurrent with load-use hazard -> stall=0, bubble out; wb to x0 with 32'hFFFF_FFFF -> x0 still reads 0.
REQ-032 opcode 7'b1110011 -> illegal=1 with DECODE_ILLEGAL_EN, else valid=0; reset mid-stream -> all outputs 0, registers read 0.
